// File: rtl/u_pkg.sv
// Shared types for the unary stream classifier: the per-vector result record
// and the derivation of the decoded-length width.
package u_pkg;

  // Upper bound on the decoded-length field; supports W up to 256.
  localparam int U_LEN_MAX_W = 8;

  typedef struct packed {
    logic                   is_unary;
    logic                   is_compl;
    logic [U_LEN_MAX_W-1:0] len;
  } u_res_t;

  function automatic int len_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/u_classify.sv
// Combinational classifier: matches x against every true-form pivot mask and,
// when allowed, every complemented pivot mask, then encodes the hit index.
module u_classify
  import u_pkg::*;
#(
  parameter int W                     = 16,
  parameter bit P_ADMIT_COMPLIMENT_EN = 1'b1
) (
  input  logic [W-1:0] x,
  input  logic         compl_en,
  output u_res_t       res
);

  localparam int LEN_W = len_w(W);

  logic [W-1:0]     true_hit;
  logic [W-1:0]     comp_hit;
  logic [LEN_W-1:0] len_v;
  logic             comp_ok;

  assign comp_ok = P_ADMIT_COMPLIMENT_EN && compl_en;

  // Pivot k covers ones in bits [k-1:0]; k stops at W-1 so all-ones never
  // matches true form, and the two forms stay disjoint on the MSB.
  always_comb begin
    logic [W-1:0] lsb_mask;
    true_hit = '0;
    comp_hit = '0;
    len_v    = '0;
    for (int k = 0; k < W; k++) begin
      lsb_mask    = (W'(1) << k) - W'(1);
      true_hit[k] = (x == lsb_mask);
      comp_hit[k] = comp_ok && (x == ~lsb_mask);
      if (true_hit[k] || comp_hit[k]) len_v = len_v | k[LEN_W-1:0];
    end
  end

  always_comb begin
    res          = '0;
    res.is_unary = (|true_hit) || (|comp_hit);
    res.is_compl = |comp_hit;
    res.len      = U_LEN_MAX_W'(len_v);
  end

endmodule

// File: rtl/u_stream.sv
// Two-stage valid/ready unary classifier: stage A captures the vector, stage B
// holds the classification that drives the outputs; saturating statistics.
module u_stream
  import u_pkg::*;
#(
  parameter int  W                     = 16,
  parameter bit  P_ADMIT_COMPLIMENT_EN = 1'b1,
  parameter int  CNT_W                 = 16,
  localparam int LEN_W                 = len_w(W)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [W-1:0]     i_x,
  input  logic             i_compl_en,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_is_unary,
  output logic             o_is_compl,
  output logic [LEN_W-1:0] o_len,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_acc_cnt,
  output logic [CNT_W-1:0] o_rej_cnt
);

  logic         vld_p0, vld_p1;
  logic         rdy_p0, rdy_p1;
  logic         fire;
  logic [W-1:0] x_p0;
  logic         compl_en_p0;
  u_res_t       res_a, res_p1;
  logic         unused_len_hi;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic             en);
    return (en && (cnt != {CNT_W{1'b1}})) ? cnt + CNT_W'(1) : cnt;
  endfunction

  assign rdy_p1  = !vld_p1 || o_ready;
  assign rdy_p0  = !vld_p0 || rdy_p1;
  assign i_ready = rdy_p0;
  assign fire    = vld_p1 && o_ready;

  // Stage A: capture vector and its complement enable
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)     vld_p0 <= 1'b0;
    else if (rdy_p0) vld_p0 <= i_valid;
  end

  always_ff @(posedge clk) begin
    if (i_valid && rdy_p0) begin
      x_p0        <= i_x;
      compl_en_p0 <= i_compl_en;
    end
  end

  u_classify #(
    .W                    (W),
    .P_ADMIT_COMPLIMENT_EN(P_ADMIT_COMPLIMENT_EN)
  ) u_classify_i (
    .x       (x_p0),
    .compl_en(compl_en_p0),
    .res     (res_a)
  );

  // Stage B: registered classification drives the outputs
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
    end else if (rdy_p1) begin
      vld_p1 <= vld_p0;
      if (vld_p0) res_p1 <= res_a;
    end
  end

  // Statistics: clear has priority over a same-cycle delivery
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      o_acc_cnt <= '0;
      o_rej_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_acc_cnt <= '0;
      o_rej_cnt <= '0;
    end else begin
      o_acc_cnt <= sat_inc(o_acc_cnt, fire && res_p1.is_unary);
      o_rej_cnt <= sat_inc(o_rej_cnt, fire && !res_p1.is_unary);
    end
  end

  assign o_valid       = vld_p1;
  assign o_is_unary    = res_p1.is_unary;
  assign o_is_compl    = res_p1.is_compl;
  assign o_len         = res_p1.len[LEN_W-1:0];
  assign unused_len_hi = |res_p1.len;

endmodule

// File: tb/tb_u_stream.sv
// Scoreboard bench for u_stream (W=8, CNT_W=4): accepted inputs push a modelled
// result, delivered outputs pop and compare in order.
module tb_u_stream;

  localparam int W     = 8;
  localparam int CNT_W = 4;
  localparam int LEN_W = 3;

  typedef struct packed {
    logic             u;
    logic             c;
    logic [LEN_W-1:0] len;
  } exp_t;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_ready;
  logic [W-1:0]     i_x = '0;
  logic             i_compl_en = 1'b0;
  logic             o_valid;
  logic             o_ready = 1'b0;
  logic             o_is_unary;
  logic             o_is_compl;
  logic [LEN_W-1:0] o_len;
  logic             i_cnt_clr = 1'b0;
  logic [CNT_W-1:0] o_acc_cnt;
  logic [CNT_W-1:0] o_rej_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  u_stream #(
    .W                    (W),
    .P_ADMIT_COMPLIMENT_EN(1'b1),
    .CNT_W                (CNT_W)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_x       (i_x),
    .i_compl_en(i_compl_en),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_is_unary(o_is_unary),
    .o_is_compl(o_is_compl),
    .o_len     (o_len),
    .i_cnt_clr (i_cnt_clr),
    .o_acc_cnt (o_acc_cnt),
    .o_rej_cnt (o_rej_cnt)
  );

  function automatic exp_t model(input logic [W-1:0] x, input logic ce);
    exp_t         r;
    logic [W-1:0] m;
    r = '0;
    for (int k = 0; k < W; k++) begin
      m = W'((1 << k) - 1);
      if (x == m) begin
        r.u = 1'b1; r.len = LEN_W'(k);
      end
      if (ce && (x == ~m)) begin
        r.u = 1'b1; r.c = 1'b1; r.len = LEN_W'(k);
      end
    end
    return r;
  endfunction

  // One clock: sample at the falling edge, then return just after the rising edge.
  task automatic step(output logic acc);
    exp_t e;
    @(negedge clk);
    acc = arst_n && i_valid && i_ready;
    if (acc) exp_q.push_back(model(i_x, i_compl_en));
    if (arst_n && o_valid && o_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got result u=%b c=%b len=%0d, required none", o_is_unary, o_is_compl, o_len);
      end else begin
        e = exp_q.pop_front();
        if (o_is_unary !== e.u || o_is_compl !== e.c || o_len !== e.len) begin
          errors++;
          $display("FAIL sb_result: got u=%b c=%b len=%0d, required u=%b c=%b len=%0d",
                   o_is_unary, o_is_compl, o_len, e.u, e.c, e.len);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic ce);
    logic a;
    int   n;
    a = 1'b0; n = 0;
    i_valid = 1'b1; i_x = x; i_compl_en = ce;
    while (!a && n < 50) begin
      step(a); n++;
    end
    checks++;
    if (!a) begin
      errors++;
      $display("FAIL send_timeout: got no accept for %h, required accept within 50 cycles", x);
    end
    i_valid = 1'b0;
  endtask

  task automatic drain();
    logic a;
    int   n;
    n = 0;
    o_ready = 1'b1;
    while (exp_q.size() != 0 && n < 20) begin
      step(a); n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_valid, o_is_unary, o_is_compl} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b, required 000", {o_valid, o_is_unary, o_is_compl});
    end
    checks++;
    if (o_len !== '0) begin
      errors++; $display("FAIL reset_len: got %0d, required 0", o_len);
    end
    checks++;
    if (o_acc_cnt !== '0 || o_rej_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt: got acc=%0d rej=%0d, required 0/0", o_acc_cnt, o_rej_cnt);
    end
    checks++;
    if (i_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b, required 1", i_ready);
    end
    arst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic a;
    o_ready = 1'b1;
    i_valid = 1'b1; i_x = 8'h07; i_compl_en = 1'b0;
    step(a);
    i_valid = 1'b0;
    checks++;
    if (!a || o_valid !== 1'b0) begin
      errors++; $display("FAIL basic_lat1: got acc=%b o_valid=%b, required 1/0", a, o_valid);
    end
    step(a);
    checks++;
    if (o_valid !== 1'b1 || o_is_unary !== 1'b1 || o_is_compl !== 1'b0 || o_len !== 3'd3) begin
      errors++;
      $display("FAIL basic_out: got v=%b u=%b c=%b len=%0d, required 1/1/0/3", o_valid, o_is_unary, o_is_compl, o_len);
    end
    step(a);
    checks++;
    if (o_acc_cnt !== 4'd1 || o_rej_cnt !== 4'd0) begin
      errors++; $display("FAIL basic_cnt: got acc=%0d rej=%0d, required 1/0", o_acc_cnt, o_rej_cnt);
    end
  endtask

  task automatic test_forms();
    o_ready = 1'b1;
    send(8'hF8, 1'b1);
    send(8'hF8, 1'b0);
    drain();
    checks++;
    if (o_acc_cnt !== 4'd2 || o_rej_cnt !== 4'd1) begin
      errors++; $display("FAIL forms_cnt: got acc=%0d rej=%0d, required 2/1", o_acc_cnt, o_rej_cnt);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] xs[9];
    logic         ces[9];
    xs  = '{8'h00, 8'hFF, 8'hFF, 8'h80, 8'h05, 8'h7F, 8'h80, 8'hFE, 8'h0F};
    ces = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
    o_ready = 1'b1;
    for (int i = 0; i < 9; i++) send(xs[i], ces[i]);
    drain();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] vec[3];
    logic         a;
    int           idx, n;
    vec = '{8'h01, 8'h03, 8'h07};
    idx = 0; a = 1'b0;
    o_ready = 1'b0;
    i_valid = 1'b1; i_x = vec[0]; i_compl_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(a);
      if (a) idx++;
      if (idx < 3) i_x = vec[idx];
      else i_valid = 1'b0;
      if (c >= 1) begin
        checks++;
        if (o_valid !== 1'b1 || o_is_unary !== 1'b1 || o_len !== 3'd1) begin
          errors++; $display("FAIL bp_hold: got v=%b u=%b len=%0d at cycle %0d, required 1/1/1", o_valid, o_is_unary, o_len, c);
        end
      end
    end
    checks++;
    if (idx != 2 || i_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready: got accepts=%0d i_ready=%b, required 2/0", idx, i_ready);
    end
    o_ready = 1'b1;
    n = 0;
    while (idx < 3 && n < 20) begin
      step(a);
      if (a) idx++;
      n++;
    end
    i_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    logic a;
    int   k;
    a = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (!i_valid || a) begin
        i_valid = ($urandom_range(0, 3) != 0);
        k = $urandom_range(0, 7);
        case ($urandom_range(0, 2))
          0:       i_x = W'((1 << k) - 1);
          1:       i_x = ~W'((1 << k) - 1);
          default: i_x = W'($urandom);
        endcase
        i_compl_en = $urandom_range(0, 1) != 0;
      end
      o_ready = ($urandom_range(0, 3) != 0);
      step(a);
    end
    i_valid = 1'b0;
    drain();
  endtask

  task automatic test_counters();
    logic a;
    int   n;
    o_ready = 1'b1;
    i_cnt_clr = 1'b1;
    step(a);
    i_cnt_clr = 1'b0;
    checks++;
    if (o_acc_cnt !== '0 || o_rej_cnt !== '0) begin
      errors++; $display("FAIL cnt_clear: got acc=%0d rej=%0d, required 0/0", o_acc_cnt, o_rej_cnt);
    end
    for (int i = 0; i < 20; i++) send(8'h03, 1'b0);
    drain();
    checks++;
    if (o_acc_cnt !== 4'd15 || o_rej_cnt !== 4'd0) begin
      errors++; $display("FAIL cnt_sat: got acc=%0d rej=%0d, required 15/0", o_acc_cnt, o_rej_cnt);
    end
    o_ready = 1'b0;
    send(8'h05, 1'b0);
    n = 0;
    while (o_valid !== 1'b1 && n < 10) begin
      step(a); n++;
    end
    checks++;
    if (o_valid !== 1'b1 || o_acc_cnt !== 4'd15) begin
      errors++; $display("FAIL cnt_pre: got v=%b acc=%0d, required 1/15", o_valid, o_acc_cnt);
    end
    o_ready = 1'b1; i_cnt_clr = 1'b1;
    step(a);
    i_cnt_clr = 1'b0;
    checks++;
    if (o_acc_cnt !== '0 || o_rej_cnt !== '0 || o_valid !== 1'b0) begin
      errors++; $display("FAIL cnt_clr_fire: got acc=%0d rej=%0d v=%b, required 0/0/0", o_acc_cnt, o_rej_cnt, o_valid);
    end
  endtask

  task automatic test_async_reset();
    logic a;
    o_ready = 1'b1;
    send(8'h05, 1'b0);
    drain();
    checks++;
    if (o_rej_cnt !== 4'd1) begin
      errors++; $display("FAIL ar_pre_cnt: got rej=%0d, required 1", o_rej_cnt);
    end
    o_ready = 1'b0;
    send(8'h01, 1'b0);
    send(8'h03, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || i_ready !== 1'b0) begin
      errors++; $display("FAIL ar_full: got v=%b i_ready=%b, required 1/0", o_valid, i_ready);
    end
    #2 arst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_rej_cnt !== '0 || o_acc_cnt !== '0 || o_len !== '0 || i_ready !== 1'b1) begin
      errors++;
      $display("FAIL ar_immediate: got v=%b acc=%0d rej=%0d len=%0d i_ready=%b, required 0/0/0/0/1",
               o_valid, o_acc_cnt, o_rej_cnt, o_len, i_ready);
    end
    exp_q.delete();
    step(a);
    step(a);
    arst_n = 1'b1;
    o_ready = 1'b1;
    i_valid = 1'b1; i_x = 8'h07; i_compl_en = 1'b0;
    step(a);
    i_valid = 1'b0;
    checks++;
    if (!a || o_valid !== 1'b0) begin
      errors++; $display("FAIL ar_lat1: got acc=%b v=%b, required 1/0", a, o_valid);
    end
    step(a);
    checks++;
    if (o_valid !== 1'b1 || o_len !== 3'd3 || o_is_unary !== 1'b1) begin
      errors++; $display("FAIL ar_lat2: got v=%b u=%b len=%0d, required 1/1/3", o_valid, o_is_unary, o_len);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_forms();
    test_boundaries();
    test_backpressure();
    test_back_to_back();
    test_counters();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
